// File: rtl/vga_pattern_gen.sv
// Pixel-colour stage for the VGA timing generator.
// Drives three selectable test patterns: colour bars, checkerboard and a
// bouncing box. A debounced push button cycles between them. Colour and
// syncs are registered together, so they leave this block pixel-aligned.
module vga_pattern_gen #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int CHECK_LOG2      = 5,
  parameter int BOX_SIZE        = 64,
  parameter int BOX_SPEED       = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       valid,
  input  logic       newframe,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       mode_btn,
  output logic       r,
  output logic       g,
  output logic       b,
  output logic       hs,
  output logic       vs,
  output logic [1:0] mode
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [10:0] H_LIM = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] SPEED = 11'(BOX_SPEED);
  localparam logic [10:0] BOX_W = 11'(BOX_SIZE);

  // Button synchroniser and debouncer state
  logic             r_btn_meta;
  logic             r_btn_sync;
  logic             r_db_state;
  logic [CNT_W-1:0] r_db_cnt;
  logic             r_press;

  // Mode sequencing
  logic [1:0] r_mode;
  logic       r_pending;
  logic [1:0] w_mode_next;

  // Box position (11 bits so all edge arithmetic is overflow-free)
  logic [10:0] r_bx;
  logic [10:0] r_by;
  logic        r_left;
  logic        r_up;
  logic [11:0] w_h_step;
  logic [11:0] w_v_step;

  // Pixel path
  logic [10:0] w_x11;
  logic [10:0] w_y11;
  logic [2:0]  w_bar;
  logic        w_in_box;
  logic [2:0]  w_rgb;
  logic [2:0]  r_rgb_p1;
  logic        r_hs_p1;
  logic        r_vs_p1;

  // Bar colours left to right: white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [2:0] bar_colour(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = 3'b111;
      3'd1:    c = 3'b110;
      3'd2:    c = 3'b011;
      3'd3:    c = 3'b010;
      3'd4:    c = 3'b101;
      3'd5:    c = 3'b100;
      3'd6:    c = 3'b001;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

  // One axis of box motion: returns {new_backwards, new_position}.
  // Overshoot is clamped onto the wall and the direction reverses there.
  function automatic logic [11:0] step_axis(input logic [10:0] pos,
                                            input logic        back,
                                            input logic [10:0] lim);
    logic [11:0] res;
    if (!back) begin
      if (pos + SPEED >= lim) res = {1'b1, lim};
      else                    res = {1'b0, pos + SPEED};
    end else begin
      if (pos <= SPEED)       res = {1'b0, 11'd0};
      else                    res = {1'b1, pos - SPEED};
    end
    return res;
  endfunction

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
    end else begin
      r_btn_meta <= mode_btn;
      r_btn_sync <= r_btn_meta;
    end
  end

  // Debouncer: accept a change only after it persists; pulse on accepted press
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_state <= 1'b0;
      r_db_cnt   <= '0;
      r_press    <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_btn_sync != r_db_state) begin
        if (r_db_cnt == CNT_LAST) begin
          r_db_state <= r_btn_sync;
          r_db_cnt   <= '0;
          r_press    <= r_btn_sync;
        end else begin
          r_db_cnt <= r_db_cnt + CNT_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // Next pattern in the 0 -> 1 -> 2 -> 0 cycle; 3 is folded back to 0
  always_comb begin
    w_mode_next = 2'd0;
    if (r_mode == 2'd0)      w_mode_next = 2'd1;
    else if (r_mode == 2'd1) w_mode_next = 2'd2;
  end

  // Presses are latched and applied once at the next frame start
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode    <= 2'd0;
      r_pending <= 1'b0;
    end else if (newframe && (r_pending || r_press)) begin
      r_mode    <= w_mode_next;
      r_pending <= 1'b0;
    end else if (r_press) begin
      r_pending <= 1'b1;
    end
  end

  // Candidate box positions for the next frame
  always_comb begin
    w_h_step = step_axis(r_bx, r_left, H_LIM);
    w_v_step = step_axis(r_by, r_up, V_LIM);
  end

  // Box moves once per frame regardless of the displayed pattern
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bx   <= 11'd0;
      r_by   <= 11'd0;
      r_left <= 1'b0;
      r_up   <= 1'b0;
    end else if (newframe) begin
      r_bx   <= w_h_step[10:0];
      r_left <= w_h_step[11];
      r_by   <= w_v_step[10:0];
      r_up   <= w_v_step[11];
    end
  end

  // Bar index by threshold comparisons against constant bar edges
  always_comb begin
    w_x11 = {1'b0, x};
    w_y11 = {1'b0, y};
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (w_x11 >= 11'(k * BAR_W)) w_bar = 3'(k);
    end
    w_in_box = (w_x11 >= r_bx) && (w_x11 < r_bx + BOX_W) &&
               (w_y11 >= r_by) && (w_y11 < r_by + BOX_W);
  end

  // Pattern colour for the current pixel; black during blanking
  always_comb begin
    w_rgb = 3'b000;
    if (valid) begin
      case (r_mode)
        2'd1:    w_rgb = (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? 3'b111 : 3'b000;
        2'd2:    w_rgb = w_in_box ? 3'b111 : 3'b001;
        default: w_rgb = bar_colour(w_bar);
      endcase
    end
  end

  // Output register: colour and syncs share one cycle of latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb_p1 <= 3'b000;
      r_hs_p1  <= 1'b0;
      r_vs_p1  <= 1'b0;
    end else begin
      r_rgb_p1 <= w_rgb;
      r_hs_p1  <= hsync_in;
      r_vs_p1  <= vsync_in;
    end
  end

  assign r    = r_rgb_p1[2];
  assign g    = r_rgb_p1[1];
  assign b    = r_rgb_p1[0];
  assign hs   = r_hs_p1;
  assign vs   = r_vs_p1;
  assign mode = r_mode;

endmodule
